// File: rtl/apb_master.sv
// APB initiator: converts a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns one response per command, with optional stall timeout.
module apb_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  accept;

  // Ready in IDLE, or on the completing ACCESS cycle to chain the next command.
  assign cmd_ready = PRESETn && ((state_q == S_IDLE) || ((state_q == S_ACCESS) && PREADY));
  assign accept    = cmd_valid && cmd_ready;

  assign PSEL        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PENABLE     = (state_q == S_ACCESS);
  assign busy        = (state_q != S_IDLE);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    // Address/data registers change only on accept so they hold across IDLE.
    if (accept) begin
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_wdata;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
      end
      S_ACCESS: begin
        if (PREADY) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = accept ? S_SETUP : S_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: instance A (TIMEOUT=4) with a memory slave,
// instance B (TIMEOUT=0) with a fixed-data slave.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESETn;

  logic        a_cmd_valid, a_cmd_ready, a_cmd_write;
  logic [31:0] a_cmd_addr, a_cmd_wdata;
  logic        a_rsp_valid, a_rsp_err, a_rsp_timeout, a_busy;
  logic [31:0] a_rsp_rdata;
  logic        a_psel, a_penable, a_pwrite, a_pready, a_pslverr;
  logic [31:0] a_paddr, a_pwdata, a_prdata;

  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [31:0] b_cmd_addr, b_cmd_wdata;
  logic        b_rsp_valid, b_rsp_err, b_rsp_timeout, b_busy;
  logic [31:0] b_rsp_rdata;
  logic        b_psel, b_penable, b_pwrite, b_pready, b_pslverr;
  logic [31:0] b_paddr, b_pwdata, b_prdata;

  logic [31:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) u_a (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
    .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .rsp_timeout(a_rsp_timeout), .busy(a_busy),
    .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite), .PADDR(a_paddr),
    .PWDATA(a_pwdata), .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr)
  );

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)) u_b (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .rsp_timeout(b_rsp_timeout), .busy(b_busy),
    .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr),
    .PWDATA(b_pwdata), .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
  );

  // Memory slave for A: writes land on the completing ACCESS edge.
  always @(posedge PCLK)
    if (a_psel && a_penable && a_pready && a_pwrite) mem[a_paddr[9:2]] <= a_pwdata;
  assign a_prdata  = mem[a_paddr[9:2]];
  assign b_prdata  = 32'hCAFE0001;
  assign b_pslverr = 1'b0;

  task automatic test_reset();
    @(negedge PCLK); @(negedge PCLK); #1;
    checks++; if (a_psel !== 1'b0) begin errors++; $display("FAIL reset_psel: got %b want 0", a_psel); end
    checks++; if (a_penable !== 1'b0) begin errors++; $display("FAIL reset_penable: got %b want 0", a_penable); end
    checks++; if (a_pwrite !== 1'b0 || a_paddr !== 32'h0 || a_pwdata !== 32'h0)
      begin errors++; $display("FAIL reset_regs: got pwrite=%b paddr=%h pwdata=%h want 0", a_pwrite, a_paddr, a_pwdata); end
    checks++; if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0 || a_rsp_timeout !== 1'b0)
      begin errors++; $display("FAIL reset_rsp: got v=%b d=%h e=%b t=%b want 0", a_rsp_valid, a_rsp_rdata, a_rsp_err, a_rsp_timeout); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (a_cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", a_cmd_ready); end
    @(negedge PCLK); PRESETn = 1'b1; #1;
    checks++; if (a_cmd_ready !== 1'b1) begin errors++; $display("FAIL release_cmd_ready: got %b want 1", a_cmd_ready); end
  endtask

  task automatic test_write();
    int psel_n = 0, pen_n = 0, rsp_n = 0, rsp_at = 0;
    logic [31:0] rdata = 32'hFFFF_FFFF;
    logic err = 1'bx, bus_ok = 1'b1;
    @(negedge PCLK);
    a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_addr = 32'h10; a_cmd_wdata = 32'hDEADBEEF;
    a_pready = 1'b1; a_pslverr = 1'b0; #1;
    checks++; if (a_cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", a_cmd_ready); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge PCLK); a_cmd_valid = 1'b0; #1;
      if (a_psel) begin
        psel_n++;
        if (a_paddr !== 32'h10 || a_pwdata !== 32'hDEADBEEF || a_pwrite !== 1'b1) bus_ok = 1'b0;
      end
      if (a_penable) pen_n++;
      if (a_rsp_valid) begin rsp_n++; rsp_at = i; rdata = a_rsp_rdata; err = a_rsp_err; end
    end
    checks++; if (psel_n !== 2) begin errors++; $display("FAIL wr_psel_cycles: got %0d want 2", psel_n); end
    checks++; if (pen_n !== 1) begin errors++; $display("FAIL wr_penable_cycles: got %0d want 1", pen_n); end
    checks++; if (bus_ok !== 1'b1) begin errors++; $display("FAIL wr_bus_values: got bad PADDR/PWDATA/PWRITE want 10/deadbeef/1"); end
    checks++; if (rsp_n !== 1 || rsp_at !== 3) begin errors++; $display("FAIL wr_rsp_timing: got n=%0d at=%0d want n=1 at=3", rsp_n, rsp_at); end
    checks++; if (rdata !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL wr_rsp_data: got d=%h e=%b want 0/0", rdata, err); end
  endtask

  task automatic test_read();
    int rsp_at = 0;
    logic [31:0] rdata = 32'h0;
    @(negedge PCLK);
    a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_addr = 32'h10; #1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge PCLK); a_cmd_valid = 1'b0; #1;
      if (i == 2) begin
        checks++; if (a_pwrite !== 1'b0 || a_penable !== 1'b1)
          begin errors++; $display("FAIL rd_access: got pwrite=%b penable=%b want 0/1", a_pwrite, a_penable); end
      end
      if (a_rsp_valid) begin rsp_at = i; rdata = a_rsp_rdata; end
    end
    checks++; if (rsp_at !== 3 || rdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL rd_rsp: got at=%0d d=%h want at=3 d=deadbeef", rsp_at, rdata); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] psel_pat = 4'h0, pen_pat = 4'h0;
    int rsp_n = 0, t0 = 0, t1 = 0;
    logic [31:0] rd0 = 32'hFFFF_FFFF, rd1 = 32'h0;
    @(negedge PCLK);
    a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_addr = 32'h20; a_cmd_wdata = 32'h12345678; #1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge PCLK);
      if (i == 1) a_cmd_write = 1'b0;
      if (i == 3) a_cmd_valid = 1'b0;
      #1;
      if (i <= 4) begin psel_pat = {psel_pat[2:0], a_psel}; pen_pat = {pen_pat[2:0], a_penable}; end
      if (a_rsp_valid) begin
        if (rsp_n == 0) begin t0 = i; rd0 = a_rsp_rdata; end
        else begin t1 = i; rd1 = a_rsp_rdata; end
        rsp_n++;
      end
    end
    checks++; if (psel_pat !== 4'b1111) begin errors++; $display("FAIL b2b_psel: got %b want 1111", psel_pat); end
    checks++; if (pen_pat !== 4'b0101) begin errors++; $display("FAIL b2b_penable: got %b want 0101", pen_pat); end
    checks++; if (rsp_n !== 2 || t0 !== 3 || t1 !== 5)
      begin errors++; $display("FAIL b2b_rsp_timing: got n=%0d t0=%0d t1=%0d want 2/3/5", rsp_n, t0, t1); end
    checks++; if (rd0 !== 32'h0 || rd1 !== 32'h12345678)
      begin errors++; $display("FAIL b2b_rsp_data: got %h %h want 0 12345678", rd0, rd1); end
  endtask

  task automatic test_wait_err();
    int psel_n = 0, stable_n = 0, pen_n = 0, rsp_at = 0;
    logic err = 1'b0, to = 1'b1;
    @(negedge PCLK);
    a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_addr = 32'h30; a_cmd_wdata = 32'hA5A5A5A5;
    a_pready = 1'b0; #1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge PCLK);
      if (i == 1) a_cmd_valid = 1'b0;
      if (i == 5) begin a_pready = 1'b1; a_pslverr = 1'b1; end
      if (i == 6) a_pslverr = 1'b0;
      #1;
      if (a_psel) begin
        psel_n++;
        if (a_paddr === 32'h30 && a_pwrite === 1'b1 && a_pwdata === 32'hA5A5A5A5) stable_n++;
      end
      if (a_penable) pen_n++;
      if (i == 3) begin
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b want 1", a_busy); end
      end
      if (a_rsp_valid) begin rsp_at = i; err = a_rsp_err; to = a_rsp_timeout; end
    end
    checks++; if (psel_n !== 5 || stable_n !== 5)
      begin errors++; $display("FAIL wait_stable: got psel=%0d stable=%0d want 5/5", psel_n, stable_n); end
    checks++; if (pen_n !== 4) begin errors++; $display("FAIL wait_access_cycles: got %0d want 4", pen_n); end
    checks++; if (rsp_at !== 6 || err !== 1'b1 || to !== 1'b0)
      begin errors++; $display("FAIL wait_rsp: got at=%0d e=%b t=%b want 6/1/0", rsp_at, err, to); end
  endtask

  task automatic test_timeout();
    int pen_n = 0, rsp_n = 0, rsp_at = 0;
    logic err = 1'b0, to = 1'b0, ready5 = 1'b1, ready6 = 1'b0, psel6 = 1'b1, busy6 = 1'b1;
    logic [31:0] rdata = 32'hFFFF_FFFF;
    @(negedge PCLK);
    a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_addr = 32'h40; a_pready = 1'b0; #1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge PCLK);
      if (i == 1) a_cmd_valid = 1'b0;
      #1;
      if (a_penable) pen_n++;
      if (i == 5) ready5 = a_cmd_ready;
      if (i == 6) begin ready6 = a_cmd_ready; psel6 = a_psel | a_penable; busy6 = a_busy; end
      if (a_rsp_valid) begin rsp_n++; rsp_at = i; rdata = a_rsp_rdata; err = a_rsp_err; to = a_rsp_timeout; end
    end
    a_pready = 1'b1;
    checks++; if (pen_n !== 4) begin errors++; $display("FAIL to_access_cycles: got %0d want 4", pen_n); end
    checks++; if (rsp_n !== 1 || rsp_at !== 6)
      begin errors++; $display("FAIL to_rsp_timing: got n=%0d at=%0d want 1/6", rsp_n, rsp_at); end
    checks++; if (err !== 1'b1 || to !== 1'b1 || rdata !== 32'h0)
      begin errors++; $display("FAIL to_rsp_fields: got e=%b t=%b d=%h want 1/1/0", err, to, rdata); end
    checks++; if (ready5 !== 1'b0 || ready6 !== 1'b1)
      begin errors++; $display("FAIL to_cmd_ready: got abort=%b next=%b want 0/1", ready5, ready6); end
    checks++; if (psel6 !== 1'b0 || busy6 !== 1'b0)
      begin errors++; $display("FAIL to_idle: got psel|penable=%b busy=%b want 0/0", psel6, busy6); end
  endtask

  task automatic test_reset_mid();
    int rsp_seen = 0, rsp_at = 0;
    logic [31:0] rdata = 32'h0;
    @(negedge PCLK);
    a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_addr = 32'h10; a_pready = 1'b0; #1;
    @(negedge PCLK); a_cmd_valid = 1'b0;
    @(negedge PCLK); #1;
    checks++; if (a_penable !== 1'b1) begin errors++; $display("FAIL rst_mid_access: got penable=%b want 1", a_penable); end
    #2 PRESETn = 1'b0; #1;
    checks++; if (a_psel !== 1'b0 || a_penable !== 1'b0 || a_paddr !== 32'h0)
      begin errors++; $display("FAIL rst_mid_bus: got psel=%b penable=%b paddr=%h want 0/0/0", a_psel, a_penable, a_paddr); end
    checks++; if (a_busy !== 1'b0 || a_cmd_ready !== 1'b0)
      begin errors++; $display("FAIL rst_mid_ctrl: got busy=%b ready=%b want 0/0", a_busy, a_cmd_ready); end
    a_pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK); #1;
      if (a_rsp_valid !== 1'b0) rsp_seen++;
    end
    @(negedge PCLK); PRESETn = 1'b1;
    a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_addr = 32'h10; #1;
    if (a_rsp_valid !== 1'b0) rsp_seen++;
    for (int i = 1; i <= 5; i++) begin
      @(negedge PCLK); a_cmd_valid = 1'b0; #1;
      if (a_rsp_valid) begin rsp_at = i; rdata = a_rsp_rdata; end
    end
    checks++; if (rsp_seen !== 0) begin errors++; $display("FAIL rst_mid_no_rsp: got %0d responses want 0", rsp_seen); end
    checks++; if (rsp_at !== 3 || rdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL rst_mid_reread: got at=%0d d=%h want 3/deadbeef", rsp_at, rdata); end
  endtask

  task automatic test_no_timeout();
    int pen_n = 0, rsp_at = 0;
    logic err = 1'b1, to = 1'b1, bus_ok = 1'b1;
    logic [31:0] rdata = 32'h0;
    @(negedge PCLK);
    b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 32'h50; b_pready = 1'b0; #1;
    checks++; if (b_cmd_ready !== 1'b1 || b_pwdata !== 32'h0)
      begin errors++; $display("FAIL nto_idle: got ready=%b pwdata=%h want 1/0", b_cmd_ready, b_pwdata); end
    for (int i = 1; i <= 150; i++) begin
      @(negedge PCLK);
      if (i == 1) b_cmd_valid = 1'b0;
      if (i == 102) b_pready = 1'b1;
      #1;
      if (b_penable) begin
        pen_n++;
        if (b_psel !== 1'b1 || b_paddr !== 32'h50 || b_pwrite !== 1'b0 || b_busy !== 1'b1) bus_ok = 1'b0;
      end
      if (b_rsp_valid) begin rsp_at = i; rdata = b_rsp_rdata; err = b_rsp_err; to = b_rsp_timeout; break; end
    end
    checks++; if (rsp_at !== 103) begin errors++; $display("FAIL nto_rsp_timing: got at=%0d want 103 (0 = none within bound)", rsp_at); end
    checks++; if (pen_n !== 101 || bus_ok !== 1'b1)
      begin errors++; $display("FAIL nto_access: got cycles=%0d bus_ok=%b want 101/1", pen_n, bus_ok); end
    checks++; if (to !== 1'b0 || err !== 1'b0 || rdata !== 32'hCAFE0001)
      begin errors++; $display("FAIL nto_rsp_fields: got t=%b e=%b d=%h want 0/0/cafe0001", to, err, rdata); end
  endtask

  initial begin
    PRESETn = 1'b0;
    a_cmd_valid = 1'b0; a_cmd_write = 1'b0; a_cmd_addr = 32'h0; a_cmd_wdata = 32'h0;
    a_pready = 1'b1; a_pslverr = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = 32'h0; b_cmd_wdata = 32'h0;
    b_pready = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_wait_err();
    test_timeout();
    test_reset_mid();
    test_no_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-requester APB initiator that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns one response per command. It drives our APB slave peripherals (cache-backed slave and successors) from test/processor-side logic. It handles wait states (PREADY low), reports PSLVERR, and aborts transfers stalled past a programmable timeout.

## Interface
- ADDR_WIDTH, 32, PADDR / cmd_addr width
- DATA_WIDTH, 32, PWDATA / PRDATA / cmd_wdata / rsp_rdata width
- TIMEOUT, 16, maximum consecutive PREADY-low ACCESS cycles before abort; 0 disables timeout
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR sampled at completion, or 1 on timeout
- rsp_timeout  out  1  transfer aborted by timeout
- busy  out  1  state != IDLE
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

## Operation
- FSM states IDLE, SETUP, ACCESS; PSEL = (SETUP|ACCESS), PENABLE = ACCESS, decoded from state flops only.
- cmd_ready = PRESETn && (IDLE || (ACCESS && PREADY)); never asserted in a timeout-abort cycle.
- Accept: latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA registers; next state SETUP.
- SETUP: always one cycle; next ACCESS; wait counter cleared.
- ACCESS, PREADY=1: complete. rsp_valid=1 next cycle; rsp_rdata = PRDATA if read else 0; rsp_err = PSLVERR; rsp_timeout=0. Next SETUP if new command accepted same edge, else IDLE.
- ACCESS, PREADY=0: hold; counter increments. If TIMEOUT!=0 and this is the TIMEOUT-th consecutive low cycle: next IDLE, rsp_valid next cycle with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- PADDR/PWDATA/PWRITE stable from SETUP through final ACCESS cycle; retain last value in IDLE (change only on accept).
- PSLVERR/PRDATA ignored except in the completing ACCESS cycle.
- Counter width $clog2(TIMEOUT+1), saturates; no wrap.

## Timing
- Reset (async, immediate): state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, busy=0, counter=0; cmd_ready=0 while PRESETn low.
- Reset mid-transfer: transfer dropped, no response issued; PSEL falls asynchronously.
- Accept at edge N -> SETUP cycle N+1 -> ACCESS cycle N+2; zero-wait completion -> rsp_valid in cycle N+3.
- Each PREADY-low ACCESS cycle adds one cycle latency.
- Back-to-back: completion edge also accepts next command; PSEL stays high, PENABLE drops for one SETUP cycle; throughput 1 transfer / 2 cycles at zero wait.
- Timeout with TIMEOUT=T: ACCESS lasts exactly T cycles, PSEL/PENABLE low the cycle after, rsp_valid that same cycle.
- rsp_valid high exactly one cycle per accepted command (completion or timeout).

## Test plan
- Write 0xDEADBEEF to 0x10, zero-wait slave -> PSEL 2 cycles, PENABLE 1 cycle, PADDR=0x10, PWDATA=0xDEADBEEF; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read 0x10 after above -> rsp_rdata=0xDEADBEEF; back-to-back write 0x20/read 0x20 with cmd_valid held -> PSEL never drops, PENABLE toggles 0,1,0,1, two responses 2 cycles apart.
- Slave holds PREADY low 3 ACCESS cycles, PSLVERR=1 on completion -> PADDR/PWRITE stable 5 cycles, rsp_err=1, rsp_timeout=0.
- TIMEOUT=4, PREADY stuck low -> exactly 4 ACCESS cycles, then IDLE, rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0; cmd_ready low in the abort cycle, high next.
- PRESETn asserted during ACCESS of a read -> PSEL/PENABLE/PADDR=0 immediately, no rsp_valid; after release a new read to 0x10 completes normally.
- TIMEOUT=0, PREADY low 100 cycles then high -> no abort, normal response with rsp_timeout=0.
